pr_decouple_sequencer: RTL and testbench

Sequences decoupling of the N stream decouplers that fence one partial-reconfiguration (PR) region.
- On request, it asserts passive decouple to all interfaces and waits for every one to report done.
- If the drain takes too long, it escalates to decouple_force on the stragglers.
- Once all interfaces are decoupled, it holds the region in reset.
- On release, it brings the region out of reset before recoupling, then waits until every interface has actually recoupled.

---
 rtl/pr_decouple_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pr_decouple_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_decouple_sequencer.sv
// Sequences decouple, forced decouple, region reset and recouple for the stream decouplers
// fencing one partial-reconfiguration region.
module pr_decouple_sequencer #(
    parameter int unsigned NUM_IFACES        = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned RESET_HOLD_CYCLES = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_decouple,
    input  logic                  req_force,
    input  logic [NUM_IFACES-1:0] iface_decouple_done,
    input  logic [NUM_IFACES-1:0] iface_decoupled,
    output logic [NUM_IFACES-1:0] decouple_o,
    output logic [NUM_IFACES-1:0] decouple_force_o,
    output logic                  region_resetn,
    output logic                  decoupled_all,
    output logic                  timed_out,
    output logic                  busy,
    output logic [2:0]            state_o
);

    localparam int unsigned CntMax = (TIMEOUT_CYCLES > RESET_HOLD_CYCLES) ?
                                     TIMEOUT_CYCLES : RESET_HOLD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StCoupled   = 3'd0,
        StDrain     = 3'd1,
        StForce     = 3'd2,
        StDecoupled = 3'd3,
        StRelease   = 3'd4,
        StRecouple  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timed_out_q, timed_out_d;
    logic [NUM_IFACES-1:0] decouple_q, decouple_d;
    logic [NUM_IFACES-1:0] force_q, force_d;
    logic                  region_resetn_q, region_resetn_d;
    logic                  decoupled_all_q, decoupled_all_d;
    logic                  busy_q, busy_d;

    logic all_done, all_dec, none_dec;

    assign all_done = (&iface_decouple_done) && (&iface_decoupled);
    assign all_dec  = &iface_decoupled;
    assign none_dec = ~|iface_decoupled;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        timed_out_d     = timed_out_q;
        decouple_d      = '0;
        force_d         = '0;
        region_resetn_d = 1'b1;
        decoupled_all_d = 1'b0;
        busy_d          = 1'b1;

        unique case (state_q)
            StCoupled: begin
                if (req_force) begin
                    state_d = StForce;
                end else if (req_decouple) begin
                    state_d     = StDrain;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + CntW'(1);
                if (req_force) begin
                    state_d = StForce;
                end else if (!req_decouple) begin
                    state_d = StCoupled;
                end else if (all_done) begin
                    state_d = StDecoupled;
                end else if (cnt_q == DrainLast) begin
                    state_d     = StForce;
                    timed_out_d = 1'b1;
                end
            end
            StForce: begin
                if (all_dec) begin
                    state_d = StDecoupled;
                end
            end
            StDecoupled: begin
                if (!req_decouple && !req_force) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                cnt_d = cnt_q + CntW'(1);
                if (req_decouple || req_force) begin
                    state_d = StDecoupled;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRecouple;
                end
            end
            StRecouple: begin
                // Decouplers stay decoupled until their in-flight packet is dropped, so no timeout.
                if (req_force) begin
                    state_d = StForce;
                end else if (req_decouple) begin
                    state_d     = StDrain;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                end else if (none_dec) begin
                    state_d = StCoupled;
                end
            end
            default: begin
                state_d = StCoupled;
            end
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        unique case (state_d)
            StCoupled: begin
                busy_d = 1'b0;
            end
            StDrain, StRelease: begin
                decouple_d = '1;
            end
            StForce: begin
                decouple_d = '1;
                force_d    = ~iface_decoupled;
            end
            StDecoupled: begin
                decouple_d      = '1;
                region_resetn_d = 1'b0;
                decoupled_all_d = 1'b1;
                busy_d          = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= StCoupled;
            cnt_q           <= '0;
            timed_out_q     <= 1'b0;
            decouple_q      <= '0;
            force_q         <= '0;
            region_resetn_q <= 1'b0;
            decoupled_all_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timed_out_q     <= timed_out_d;
            decouple_q      <= decouple_d;
            force_q         <= force_d;
            region_resetn_q <= region_resetn_d;
            decoupled_all_q <= decoupled_all_d;
            busy_q          <= busy_d;
        end
    end

    assign decouple_o       = decouple_q;
    assign decouple_force_o = force_q;
    assign region_resetn    = region_resetn_q;
    assign decoupled_all    = decoupled_all_q;
    assign timed_out        = timed_out_q;
    assign busy             = busy_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_pr_decouple_sequencer.sv
// Scoreboard bench: directed sequences plus randomized requests and lane behaviour, checked
// cycle by cycle against a phase-level reference model.
module tb_pr_decouple_sequencer;

    localparam int unsigned N    = 4;
    localparam int unsigned TO   = 8;
    localparam int unsigned HOLD = 16;

    localparam int PH_COUPLED   = 0;
    localparam int PH_DRAIN     = 1;
    localparam int PH_FORCE     = 2;
    localparam int PH_DECOUPLED = 3;
    localparam int PH_RELEASE   = 4;
    localparam int PH_RECOUPLE  = 5;

    logic         aclk    = 1'b0;
    logic         aresetn = 1'b1;
    logic         rd      = 1'b0;
    logic         rf      = 1'b0;
    logic [N-1:0] done    = '0;
    logic [N-1:0] dec     = '0;

    logic [N-1:0] decouple_o, decouple_force_o;
    logic         region_resetn, decoupled_all, timed_out, busy;
    logic [2:0]   state_o;

    pr_decouple_sequencer #(
        .NUM_IFACES        (N),
        .TIMEOUT_CYCLES    (TO),
        .RESET_HOLD_CYCLES (HOLD)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .req_decouple        (rd),
        .req_force           (rf),
        .iface_decouple_done (done),
        .iface_decoupled     (dec),
        .decouple_o          (decouple_o),
        .decouple_force_o    (decouple_force_o),
        .region_resetn       (region_resetn),
        .decoupled_all       (decoupled_all),
        .timed_out           (timed_out),
        .busy                (busy),
        .state_o             (state_o)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [2:0]   st;
        logic [N-1:0] dcp;
        logic [N-1:0] frc;
        logic         rrn;
        logic         dall;
        logic         to;
        logic         bsy;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_exp = '0;
    int   checks   = 0;
    int   passes   = 0;

    // Reference model: current phase, cycles spent in it, sticky timeout flag.
    int   m_ph  = PH_COUPLED;
    int   m_age = 0;
    logic m_to  = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o = {state_o, decouple_o, decouple_force_o, region_resetn, decoupled_all, timed_out, busy};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t want);
        checks++;
        if (act === want) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t: got st=%0d dec=%b frc=%b rrn=%b dall=%b to=%b busy=%b ; want st=%0d dec=%b frc=%b rrn=%b dall=%b to=%b busy=%b",
                     name, $time, act.st, act.dcp, act.frc, act.rrn, act.dall, act.to, act.bsy,
                     want.st, want.dcp, want.frc, want.rrn, want.dall, want.to, want.bsy);
        end
    endtask

    task automatic model_reset();
        m_ph     = PH_COUPLED;
        m_age    = 0;
        m_to     = 1'b0;
        last_exp = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic r_d, input logic r_f, input logic [N-1:0] dn,
                              input logic [N-1:0] dc, output obs_t o);
        bit all_done, all_dec, none_dec;
        all_done = (dn == {N{1'b1}}) && (dc == {N{1'b1}});
        all_dec  = (dc == {N{1'b1}});
        none_dec = (dc == '0);
        case (m_ph)
            PH_COUPLED: begin
                if (r_f) m_ph = PH_FORCE;
                else if (r_d) begin m_ph = PH_DRAIN; m_age = 0; m_to = 1'b0; end
            end
            PH_DRAIN: begin
                if (r_f) m_ph = PH_FORCE;
                else if (!r_d) m_ph = PH_COUPLED;
                else if (all_done) m_ph = PH_DECOUPLED;
                else if (m_age + 1 == TO) begin m_ph = PH_FORCE; m_to = 1'b1; end
                else m_age++;
            end
            PH_FORCE: begin
                if (all_dec) m_ph = PH_DECOUPLED;
            end
            PH_DECOUPLED: begin
                if (!r_d && !r_f) begin m_ph = PH_RELEASE; m_age = 0; end
            end
            PH_RELEASE: begin
                if (r_d || r_f) m_ph = PH_DECOUPLED;
                else if (m_age + 1 == HOLD) m_ph = PH_RECOUPLE;
                else m_age++;
            end
            default: begin
                if (r_f) m_ph = PH_FORCE;
                else if (r_d) begin m_ph = PH_DRAIN; m_age = 0; m_to = 1'b0; end
                else if (none_dec) m_ph = PH_COUPLED;
            end
        endcase
        o      = '0;
        o.st   = 3'(m_ph);
        o.dcp  = (m_ph >= PH_DRAIN && m_ph <= PH_RELEASE) ? '1 : '0;
        o.frc  = (m_ph == PH_FORCE) ? ~dc : '0;
        o.rrn  = (m_ph != PH_DECOUPLED);
        o.dall = (m_ph == PH_DECOUPLED);
        o.to   = m_to;
        o.bsy  = !(m_ph == PH_COUPLED || m_ph == PH_DECOUPLED);
    endtask

    // Called at a negedge: apply inputs for the next posedge and queue the expected result.
    task automatic drive(input logic r_d, input logic r_f, input logic [N-1:0] dn,
                         input logic [N-1:0] dc);
        obs_t o;
        rd   = r_d;
        rf   = r_f;
        done = dn;
        dec  = dc;
        model_step(r_d, r_f, dn, dc, o);
        last_exp = o;
        exp_q.push_back(o);
        @(negedge aclk);
    endtask

    task automatic drive_n(input int n, input logic r_d, input logic r_f,
                           input logic [N-1:0] dn, input logic [N-1:0] dc);
        for (int i = 0; i < n; i++) drive(r_d, r_f, dn, dc);
    endtask

    always begin : monitor
        obs_t e;
        @(posedge aclk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cycle", observe(), e);
        end
    end

    logic [N-1:0] s_dec   = '0;
    logic [N-1:0] s_stuck = '0;
    logic         s_rd    = 1'b0;
    logic         s_rf    = 1'b0;

    task automatic rand_cycles(input int n);
        logic want;
        for (int i = 0; i < n; i++) begin
            if (m_ph == PH_COUPLED)
                s_stuck = ($urandom_range(0, 2) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
            if (s_rd) s_rd = ($urandom_range(0, 29) != 0);
            else      s_rd = ($urandom_range(0, 24) == 0);
            s_rf = ($urandom_range(0, 59) == 0);
            // Lanes follow decouple with random latency; a stuck lane only yields to force.
            for (int j = 0; j < N; j++) begin
                if (!last_exp.dcp[j]) want = 1'b0;
                else if (s_stuck[j] && !last_exp.frc[j] && !s_dec[j]) want = 1'b0;
                else want = 1'b1;
                if (s_dec[j] != want && $urandom_range(0, 2) == 0) s_dec[j] = want;
            end
            drive(s_rd, s_rf, s_dec & ~s_stuck, s_dec);
        end
    endtask

    initial begin
        #1 aresetn = 1'b0;
        #2 check("reset_init", observe(), obs_t'('0));
        @(posedge aclk);
        #1 check("reset_hold", observe(), obs_t'('0));
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();

        // Basic decouple: all lanes done three cycles in, then release and recouple.
        drive_n(3, 1'b1, 1'b0, 4'h0, 4'h0);
        drive_n(3, 1'b1, 1'b0, 4'hF, 4'hF);
        drive_n(HOLD + 2, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(3, 1'b0, 1'b0, 4'h0, 4'h0);

        // Timeout with lane 2 stuck, then lane 2 yields to force.
        drive_n(TO + 1, 1'b1, 1'b0, 4'b1011, 4'b1011);
        drive_n(2, 1'b1, 1'b0, 4'b1011, 4'b1111);
        drive_n(HOLD + 2, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(2, 1'b0, 1'b0, 4'h0, 4'h0);

        // All done lands on the same cycle as the timeout: decoupled wins, no timeout flag.
        drive_n(TO, 1'b1, 1'b0, 4'h0, 4'h0);
        drive_n(2, 1'b1, 1'b0, 4'hF, 4'hF);

        // Re-request mid-release, then again during recouple.
        drive_n(6, 1'b0, 1'b0, 4'hF, 4'hF);
        drive(1'b1, 1'b0, 4'hF, 4'hF);
        drive_n(HOLD + 1, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(2, 1'b1, 1'b0, 4'hF, 4'hF);
        drive_n(HOLD + 2, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(2, 1'b0, 1'b0, 4'h0, 4'h0);

        // Abort in drain at cnt 3; simultaneous requests in coupled.
        drive_n(4, 1'b1, 1'b0, 4'h0, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b1, 4'h0, 4'h0);
        drive_n(2, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(HOLD + 2, 1'b0, 1'b0, 4'hF, 4'hF);
        drive_n(2, 1'b0, 1'b0, 4'h0, 4'h0);

        // Immediate force, then asynchronous reset between edges.
        drive_n(2, 1'b0, 1'b1, 4'h0, 4'h0);
        #2 aresetn = 1'b0;
        #1 check("async_reset", observe(), obs_t'('0));
        @(posedge aclk);
        #1 check("async_reset_edge", observe(), obs_t'('0));
        @(negedge aclk);
        rd = 1'b0;
        rf = 1'b0;
        aresetn = 1'b1;
        model_reset();
        drive_n(2, 1'b0, 1'b0, 4'h0, 4'h0);

        s_dec = '0;
        rand_cycles(4000);

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
